// File: rtl/quat_bitri_split_if.sv
// quat_bitri_split_if: quaternary input, binary/trinary output and completion signals of the splitter.
interface quat_bitri_split_if #(parameter int ERR_W = 8);
  logic [3:0] quatin;
  logic quatenable;
  logic [1:0] biout;
  logic [2:0] triout;
  logic bicomp;
  logic tricomp;
  logic err;
  logic [ERR_W-1:0] errcnt;
  modport master (output quatin, bicomp, tricomp, input quatenable, biout, triout, err, errcnt);
  modport slave (input quatin, bicomp, tricomp, output quatenable, biout, triout, err, errcnt);
endinterface

// File: rtl/quat_bitri_split.sv
// quat_bitri_split: NCL 1-of-4 receiver splitting each value into 1-of-2 and 1-of-3 outputs whose sum is the input.
module quat_bitri_split #(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W = 8
) (
  input logic clk,
  input logic init,
  quat_bitri_split_if.slave bus
);
  typedef enum logic [1:0] {S_NULL, S_REQD, S_EMIT, S_DRAIN} state_t;
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [3:0] q_s;
  logic bc_s, tc_s, one_hot, multi_hot;
  logic [1:0] bi_d;
  logic [2:0] tri_d;
  state_t state_q;
  logic qen_q, err_q;
  logic [1:0] bi_q;
  logic [2:0] tri_q;
  logic [ERR_W-1:0] errcnt_q;
  always_ff @(posedge clk or posedge init)
    if (init) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], {bus.tricomp, bus.bicomp, bus.quatin}};
  always_comb begin
    q_s = sync_q[SYNC_STAGES-1][3:0];
    bc_s = sync_q[SYNC_STAGES-1][4];
    tc_s = sync_q[SYNC_STAGES-1][5];
    one_hot = $onehot(q_s);
    multi_hot = (q_s != 4'd0) && !one_hot;
    // trinary takes min(v,2); binary takes whatever remains
    tri_d = {q_s[3] | q_s[2], q_s[1], q_s[0]};
    bi_d = {q_s[3], |q_s[2:0]};
  end
  always_ff @(posedge clk or posedge init)
    if (init) begin
      state_q <= S_NULL;
      qen_q <= 1'b0;
      err_q <= 1'b0;
      bi_q <= '0;
      tri_q <= '0;
      errcnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_NULL:
          if (q_s == 4'd0 && !bc_s && !tc_s) begin
            state_q <= S_REQD;
            qen_q <= 1'b1;
          end
        S_REQD:
          if (one_hot) begin
            state_q <= S_EMIT;
            qen_q <= 1'b0;
            bi_q <= bi_d;
            tri_q <= tri_d;
          end else if (multi_hot) begin
            state_q <= S_DRAIN;
            qen_q <= 1'b0;
            err_q <= 1'b1;
            errcnt_q <= errcnt_q + ERR_W'(~&errcnt_q);
          end
        S_EMIT:
          if (bc_s && tc_s) begin
            state_q <= S_NULL;
            bi_q <= '0;
            tri_q <= '0;
          end
        S_DRAIN:
          if (q_s == 4'd0) state_q <= S_NULL;
        default: state_q <= S_NULL;
      endcase
    end
  assign bus.quatenable = qen_q;
  assign bus.biout = bi_q;
  assign bus.triout = tri_q;
  assign bus.err = err_q;
  assign bus.errcnt = errcnt_q;
endmodule

// File: doc/quat_bitri_split.md
QUAT_BITRI_SPLIT -- requirements
Module: quat_bitri_split
Purpose: clocked receiver that accepts one NCL 1-of-4 quaternary value per DATA/NULL cycle and splits it into a 1-of-2 binary and a 1-of-3 trinary NCL output whose sum equals the input.

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flip-flop synchronizer stages on every asynchronous input (legal 2..4).
REQ-002 Parameter: ERR_W, default 8, width of the saturating error counter.
REQ-003 Clock: clk, input, 1 bit; the single clock, all state on its rising edge.
REQ-004 Reset: init, input, 1 bit; asynchronous, active-high.
REQ-005 quatin, input, 4 bits; 1-of-4 NCL quaternary data, all-zero = NULL.
REQ-006 quatenable, output, 1 bit; request to the quat sender, 1 = send DATA, 0 = send NULL.
REQ-007 biout, output, 2 bits; 1-of-2 NCL binary result, all-zero = NULL.
REQ-008 triout, output, 3 bits; 1-of-3 NCL trinary result, all-zero = NULL.
REQ-009 bicomp, input, 1 bit; binary consumer completion, 1 = DATA accepted, 0 = NULL accepted.
REQ-010 tricomp, input, 1 bit; trinary consumer completion, same encoding as bicomp.
REQ-011 err, output, 1 bit; one-cycle pulse on an illegal (multi-hot) quatin.
REQ-012 errcnt, output, ERR_W bits; count of illegal quatin events.

Function
REQ-013 quatin, bicomp and tricomp SHALL pass through SYNC_STAGES reset-to-0 flops; all decisions use only synchronized values (q_s, bc_s, tc_s).
REQ-014 States: S_NULL, S_REQD, S_EMIT, S_DRAIN; quatenable = 1 only in S_REQD.
REQ-015 S_NULL: biout = 0, triout = 0; go to S_REQD when q_s == 0 and bc_s == 0 and tc_s == 0, else stay.
REQ-016 S_REQD, q_s == 0 or exactly one-hot rail not yet seen: stay.
REQ-017 S_REQD, q_s exactly one-hot: capture value v, go to S_EMIT at the same edge.
REQ-018 S_REQD, q_s with 2 or more bits set: pulse err for 1 cycle, increment errcnt, go to S_DRAIN, no capture.
REQ-019 Split rule: triout = one-hot(min(v,2)); biout = one-hot(v - min(v,2)). So 0 -> (b0,t0), 1 -> (b0,t1), 2 -> (b0,t2), 3 -> (b1,t2).
REQ-020 S_EMIT: biout/triout hold the split of v; go to S_NULL when bc_s == 1 and tc_s == 1; one consumer alone SHALL NOT advance.
REQ-021 S_DRAIN: outputs NULL, quatenable = 0; go to S_NULL when q_s == 0.
REQ-022 biout, triout, quatenable and err SHALL be registered; no combinational path from any input to any output.
REQ-023 Latency: a quatin DATA edge at cycle t SHALL produce biout/triout DATA at edge t+SYNC_STAGES+1, with quatenable falling at that same edge.
REQ-024 biout and triout SHALL assert DATA at the same edge and return to NULL at the same edge; never multi-hot, never DATA outside S_EMIT.
REQ-025 errcnt SHALL saturate at all-ones; further errors still pulse err.
REQ-026 quatin changes outside S_REQD SHALL be ignored except as the q_s == 0 exit condition in S_NULL and S_DRAIN.

Reset
REQ-027 While init = 1: state = S_NULL, quatenable = 0, biout = 0, triout = 0, err = 0, errcnt = 0, all synchronizer flops = 0.
REQ-028 First edge after init falls, with inputs all zero: state = S_REQD, quatenable = 1.
REQ-029 init asserted in any state, including mid-S_EMIT, SHALL immediately force all REQ-027 values without waiting for clk; any captured v is discarded.

Verification
REQ-030 Reset release, all inputs 0 -> quatenable = 1 at the 1st edge; biout = 0, triout = 0.
REQ-031 quatin = 4'b1000, bicomp/tricomp echo outputs after 1 cycle -> biout = 2'b10, triout = 3'b100 exactly 3 edges later (SYNC_STAGES = 2); quatenable = 0; full DATA/NULL cycle returns quatenable = 1.
REQ-032 All four quatin values in sequence -> splits (b0,t0), (b0,t1), (b0,t2), (b1,t2); each bi index + tri index equals the input index.
REQ-033 quatin = 4'b0110 in S_REQD -> err high for exactly 1 cycle, errcnt = 1, outputs stay NULL, quatenable = 0 until quatin = 0 then reaches 1 via S_NULL.
REQ-034 In S_EMIT, bicomp = 1 and tricomp held 0 for 20 cycles -> outputs hold DATA; raise tricomp -> NULL on outputs 3 edges later.
REQ-035 Assert init mid-S_EMIT between edges -> outputs 0 and quatenable 0 immediately; 2^ERR_W + 3 illegal inputs -> errcnt = all-ones.
